// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: destination select, data select, load type.
package wb_pkg;

  typedef enum logic [1:0] {
    WR_RT   = 2'b00,
    WR_RD   = 2'b01,
    WR_LINK = 2'b10,
    WR_NONE = 2'b11
  } wr_sel_e;

  typedef enum logic [1:0] {
    WD_ALU  = 2'b00,
    WD_MEM  = 2'b01,
    WD_LINK = 2'b10,
    WD_AUX  = 2'b11
  } wd_sel_e;

  // Codes 5..7 are unassigned and behave as a word load.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_BU = 3'd1,
    LD_B  = 3'd2,
    LD_HU = 3'd3,
    LD_H  = 3'd4
  } ld_type_e;

endpackage

// File: rtl/wb_sel_stage_if.sv
// MEM/WB stage bundle: pipeline controls and fields in, GRF write and forwarding results out.
interface wb_sel_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  localparam int OFF_W = $clog2(DATA_W/8)
) ();
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              in_we;
  logic [1:0]        in_wr_sel;
  logic [REG_AW-1:0] in_rt;
  logic [REG_AW-1:0] in_rd;
  logic [1:0]        in_wd_sel;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_mem;
  logic [DATA_W-1:0] in_aux;
  logic [DATA_W-1:0] in_pc;
  logic [2:0]        in_ld_type;
  logic [OFF_W-1:0]  in_byte_off;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_pc;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic              ld_misalign;

  modport master (
    output stall, flush, in_valid, in_we, in_wr_sel, in_rt, in_rd, in_wd_sel,
           in_alu, in_mem, in_aux, in_pc, in_ld_type, in_byte_off,
    input  wb_we, wb_addr, wb_data, wb_pc, fwd_valid, fwd_addr, fwd_data, ld_misalign
  );

  modport slave (
    input  stall, flush, in_valid, in_we, in_wr_sel, in_rt, in_rd, in_wd_sel,
           in_alu, in_mem, in_aux, in_pc, in_ld_type, in_byte_off,
    output wb_we, wb_addr, wb_data, wb_pc, fwd_valid, fwd_addr, fwd_data, ld_misalign
  );
endinterface

// File: rtl/wb_sel_stage_load_ext.sv
// Load data extraction: little-endian byte/halfword lane select with sign/zero extension.
module load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] i_mem,
  input  logic [OFF_W-1:0]  i_byte_off,
  input  logic [2:0]        i_ld_type,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_mem >> {i_byte_off, 3'b000});
  // Halfword lane ignores byte_off[0]; the misalign flag reports it instead.
  assign w_half = 16'(i_mem >> {i_byte_off[OFF_W-1:1], 4'b0000});

  always_comb begin
    o_data     = i_mem;
    o_misalign = |i_byte_off;
    case (i_ld_type)
      LD_BU: begin
        o_data     = {{(DATA_W-8){1'b0}}, w_byte};
        o_misalign = 1'b0;
      end
      LD_B: begin
        o_data     = {{(DATA_W-8){w_byte[7]}}, w_byte};
        o_misalign = 1'b0;
      end
      LD_HU: begin
        o_data     = {{(DATA_W-16){1'b0}}, w_half};
        o_misalign = i_byte_off[0];
      end
      LD_H: begin
        o_data     = {{(DATA_W-16){w_half[15]}}, w_half};
        o_misalign = i_byte_off[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_sel_stage.sv
// MEM/WB pipeline register followed by GRF destination/data selection and hazard forwarding.
module wb_sel_stage
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  parameter int LINK_OFF = 8,
  localparam int OFF_W   = $clog2(DATA_W/8)
) (
  input logic          clk,
  input logic          reset,
  wb_sel_stage_if.slave bus
);

  logic              r_valid;
  logic              r_we;
  logic [1:0]        r_wr_sel;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [1:0]        r_wd_sel;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mem;
  logic [DATA_W-1:0] r_aux;
  logic [DATA_W-1:0] r_pc;
  logic [2:0]        r_ld_type;
  logic [OFF_W-1:0]  r_byte_off;

  logic [REG_AW-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_mis;
  logic              w_we;

  // Flush zeroes the whole stage, so a bubble also reports a clean address and data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.flush) begin
      r_valid    <= 1'b0;
      r_we       <= 1'b0;
      r_wr_sel   <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_wd_sel   <= '0;
      r_alu      <= '0;
      r_mem      <= '0;
      r_aux      <= '0;
      r_pc       <= '0;
      r_ld_type  <= '0;
      r_byte_off <= '0;
    end else if (!bus.stall) begin
      r_valid    <= bus.in_valid;
      r_we       <= bus.in_we;
      r_wr_sel   <= bus.in_wr_sel;
      r_rt       <= bus.in_rt;
      r_rd       <= bus.in_rd;
      r_wd_sel   <= bus.in_wd_sel;
      r_alu      <= bus.in_alu;
      r_mem      <= bus.in_mem;
      r_aux      <= bus.in_aux;
      r_pc       <= bus.in_pc;
      r_ld_type  <= bus.in_ld_type;
      r_byte_off <= bus.in_byte_off;
    end
  end

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .i_mem      (r_mem),
    .i_byte_off (r_byte_off),
    .i_ld_type  (r_ld_type),
    .o_data     (w_ld_data),
    .o_misalign (w_ld_mis)
  );

  always_comb begin
    w_addr = '0;
    case (r_wr_sel)
      WR_RT:   w_addr = r_rt;
      WR_RD:   w_addr = r_rd;
      WR_LINK: w_addr = REG_AW'(LINK_REG);
      default: w_addr = '0;
    endcase
  end

  always_comb begin
    w_data = r_alu;
    case (r_wd_sel)
      WD_ALU:  w_data = r_alu;
      WD_MEM:  w_data = w_ld_data;
      WD_LINK: w_data = r_pc + DATA_W'(LINK_OFF);
      default: w_data = r_aux;
    endcase
  end

  assign w_we = r_valid & r_we & (w_addr != '0);

  assign bus.wb_we       = w_we;
  assign bus.wb_addr     = w_addr;
  assign bus.wb_data     = w_data;
  assign bus.wb_pc       = r_pc;
  assign bus.fwd_valid   = w_we;
  assign bus.fwd_addr    = w_we ? w_addr : '0;
  assign bus.fwd_data    = w_data;
  assign bus.ld_misalign = r_valid & (r_wd_sel == WD_MEM) & w_ld_mis;

endmodule

// File: doc/wb_sel_stage.md
Name: wb_sel_stage

Overview:
Parametrised write-back stage for the pipelined MIPS core: the MEM/WB pipeline register plus the register-file destination and write-data selection that follows it. It replaces the single-cycle destination-address and write-data selectors. It adds stall/flush control, a valid bit, a fourth data source, load byte/halfword extraction with sign/zero extension, and a forwarding port for the hazard unit.

Parameters:
DATA_W, 32, datapath width; multiple of 16, at least 32
REG_AW, 5, register-file address width
LINK_REG, 31, destination for WRSel=2'b10 (jal/jalr link)
LINK_OFF, 8, offset added to PC for link data (delay slot)
OFF_W, $clog2(DATA_W/8), byte-offset width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  hold stage contents
flush  in  1  insert bubble
in_valid  in  1  upstream instruction valid
in_we  in  1  instruction writes GRF
in_wr_sel  in  2  00 rt, 01 rd, 10 LINK_REG, 11 none
in_rt, in_rd  in  REG_AW each  instruction fields
in_wd_sel  in  2  00 ALU, 01 MEM, 10 PC+LINK_OFF, 11 AUX
in_alu, in_mem, in_aux, in_pc  in  DATA_W each  source values
in_ld_type  in  3  0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh, others treated as lw
in_byte_off  in  OFF_W  low address bits from ALU result
wb_we  out  1  GRF write enable
wb_addr  out  REG_AW  GRF write address
wb_data  out  DATA_W  GRF write data
wb_pc  out  DATA_W  PC of instruction in WB (trace/debug)
fwd_valid  out  1  forwarding value valid
fwd_addr  out  REG_AW  forwarding register
fwd_data  out  DATA_W  forwarding value (equals wb_data)
ld_misalign  out  1  halfword load with odd offset, or word load with nonzero offset

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. Reset clears every stage register to 0, so all outputs read 0 while reset is high and after it is released.
- Stage register captures all in_* fields on the rising edge of clk.
- Priority on each edge: reset > flush > stall > load.
- flush: valid, we, wr_sel, wd_sel and ld_type are written to 0. Data fields may also be cleared; the chosen implementation zeroes all of them.
- stall (flush low): all fields hold their value.
- Latency: one cycle from in_* to the stage register. All outputs are combinational from the stage register, with no further register.
- Destination address:
  - wr_sel 00 gives rt; 01 gives rd; 10 gives LINK_REG; 11 gives 0.
- Write enable:
  - wb_we = valid & we & (wb_addr != 0).
  - A write to $0 is suppressed and wb_addr still reports 0 in that case.
- Data select:
  - 00 gives alu; 01 gives the extended load value; 10 gives pc + LINK_OFF, computed modulo 2^DATA_W; 11 gives aux.
- Load extraction (byte lanes little-endian; lane index = byte_off):
  - lbu/lb: select byte lane byte_off; zero- or sign-extend to DATA_W.
  - lhu/lh: select halfword lane byte_off[OFF_W-1:1]; byte_off[0] is ignored; zero- or sign-extend.
  - lw: mem passes through unchanged; byte_off is ignored for data.
- ld_misalign:
  - Combinational, gated by valid and wd_sel == 01.
  - It is a flag only and never alters wb_data or wb_we.
- Forwarding:
  - fwd_valid = wb_we; fwd_addr = wb_addr; fwd_data = wb_data.
  - When fwd_valid = 0, fwd_addr reads 0.
- Stall during reset or flush: reset or flush wins, and the stall has no effect on that edge.
- Reset mid-instruction: the instruction is lost and no write is produced.
- Bubble (valid = 0): wb_we = 0 regardless of the other fields. wb_data may be nonzero.

Decomposition:
- Shared package wb_pkg holds:
  - WRSel encodings (WR_RT, WR_RD, WR_LINK, WR_NONE);
  - WDSel encodings (WD_ALU, WD_MEM, WD_LINK, WD_AUX);
  - load-type encodings (LD_W, LD_BU, LD_B, LD_HU, LD_H).
- One sub-module is natural: load_ext. It is purely combinational, takes mem, byte_off and ld_type, and produces the extended data and the misalign flag. It is reused later by the DM byte-enable logic.
- The stage register and the selects stay in the top module.

Test Plan:
- Reset asserted mid-cycle with a valid ALU write loaded -> all outputs 0 immediately (asynchronous); after release with no stimulus, wb_we=0.
- Load in_valid=1, we=1, wr_sel=01, rd=9, wd_sel=00, alu=32'h1234_5678; next cycle -> wb_we=1, wb_addr=9, wb_data=32'h1234_5678; fwd_valid=1, fwd_addr=9, fwd_data=32'h1234_5678.
- Load wr_sel=10, wd_sel=10, pc=32'h0000_3000 -> wb_addr=31, wb_data=32'h0000_3008. Separately, load wr_sel=00, rt=0, we=1 -> wb_we=0, fwd_valid=0.
- mem=32'h80FF_7F01 -> required wb_data:
  - lb, off=2: 32'hFFFF_FFFF
  - lbu, off=3: 32'h0000_0080
  - lh, off=2: 32'hFFFF_80FF
  - lhu, off=0: 32'h0000_7F01
  - lh, off=1: ld_misalign=1 and data from the lower halfword
- Stall for 3 cycles while inputs change -> outputs unchanged. flush together with stall -> next edge gives wb_we=0 and valid cleared.
- Back-to-back loads on consecutive cycles with stall low -> each appears exactly one cycle later, with no drop or duplicate.
